hack_cpu_ctrl: RTL and testbench
================================

Name: hack_cpu_ctrl

Overview:
- Control/sequencing end of the Hack datapath.
- Fetches 16-bit Hack instructions, decodes them, and drives the control bits zx/nx/zy/ny/f/no and operands x/y of the team's 16-bit ALU.
- Consumes the ALU result and its zr/ng flags to update the A, D and PC registers and the data-memory write port.
- The ALU sits outside this block and is combinational, so one instruction executes per accepted cycle.

Parameters:
- RESET_PC, 15'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- instr  in  16  instruction word at address pc.
- instr_valid  in  1  instr is valid this cycle; low = stall.
- inM  in  16  data-memory read data at addressM.
- alu_x  out  16  ALU x operand, always the D register.
- alu_y  out  16  ALU y operand: inM if instr[12]=1, else the A register.
- zx, nx, zy, ny, f, no  out  1 each  ALU control bits.
- alu_o  in  16  ALU result.
- alu_zr  in  1  ALU zero flag.
- alu_ng  in  1  ALU negative flag.
- outM  out  16  data-memory write data, equal to alu_o.
- writeM  out  1  data-memory write strobe.
- addressM  out  15  A[14:0], the current (pre-update) A register.
- pc  out  15  current program counter.

Behaviour:
- Clocking: single clock domain (clk). rst is synchronous and active-high.
- Registers: A[15:0], D[15:0], PC[14:0].
- On rst: A=0, D=0, PC=RESET_PC. rst has priority over instr_valid.
- writeM is combinational, forced to 0 while rst=1 or instr_valid=0.
- Decode: instr[15]=0 is an A-instruction; instr[15]=1 is a C-instruction.
- C-instruction fields:
  - a = instr[12].
  - Compute bits instr[11:6] map to zx, nx, zy, ny, f, no in that order.
  - Destination: d1 = instr[5] → A, d2 = instr[4] → D, d3 = instr[3] → M.
  - Jump: j1 = instr[2] (<0), j2 = instr[1] (=0), j3 = instr[0] (>0).
  - instr[14:13] are ignored.
- ALU controls = instr[11:6] when instr[15]=1, else 6'b0. These are combinational and independent of instr_valid.
- A-instruction, when accepted:
  - A <= instr.
  - D unchanged.
  - PC <= PC+1.
  - writeM = 0.
- C-instruction, when accepted:
  - If d1: A <= alu_o.
  - If d2: D <= alu_o.
  - writeM = d3.
  - outM = alu_o, and addressM uses the old A in the same cycle.
- Jump condition: jmp = (j1 & alu_ng) | (j2 & alu_zr) | (j3 & ~alu_ng & ~alu_zr).
  - If jmp: PC <= old A[14:0], even when d1 also writes A this cycle.
  - Else: PC <= PC+1.
- PC increment is modulo 2^15: 15'h7FFF+1 = 15'h0000.
- Stall: instr_valid=0 means no register changes and writeM=0. The combinational outputs still track the current inputs.
- Latency: result of an accepted instruction is visible in A/D/PC on the next rising edge. No internal pipeline, no hazards.
- Reset mid-instruction: the instruction in that cycle is discarded, and no memory write occurs.

Test Plan:
- Load constant: rst for 1 cycle, then 0x0005 valid → A=0x0005, PC=1, writeM=0 throughout.
- Copy A to D: A=5, then 0xEC10 (D=A) → zx..no = 1,1,0,0,0,0; alu_y=5; D=5; PC=2.
- Memory write: A=0x0064, D=5, then 0xE308 (M=D) → writeM=1, addressM=0x064, outM=5 in that cycle; A and D unchanged.
- Jumps:
  - A=0x0010, then 0xEA87 (0;JMP) → PC=0x0010.
  - D=0, then 0xE301 (D;JGT), zr=1 → no jump, PC increments.
  - D=0xFFFF, then 0xE304 (D;JLT) → PC=A.
- Stall and wrap:
  - instr_valid=0 for 3 cycles with 0xE318 on instr → A, D, PC held; writeM=0.
  - PC=0x7FFF plus an A-instruction → PC=0x0000.
- Reset priority: rst=1 with valid 0xE308 present → writeM=0; next cycle A=D=0, PC=RESET_PC.

Source files
------------

// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: Hack instruction decode, A/D/PC registers and sequencing around an external combinational ALU
module hack_cpu_ctrl #(
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  input  logic [15:0] inM,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        zx,
  output logic        nx,
  output logic        zy,
  output logic        ny,
  output logic        f,
  output logic        no,
  input  logic [15:0] alu_o,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [14:0] addressM,
  output logic [14:0] pc
);
  logic [15:0] a;
  logic [15:0] d;
  logic [14:0] pc_q;
  logic        is_c;
  logic        jmp;
  assign is_c = instr[15];
  assign {zx, nx, zy, ny, f, no} = is_c ? instr[11:6] : 6'b0;
  assign alu_x = d;
  assign alu_y = instr[12] ? inM : a;
  assign jmp = is_c & ((instr[2] & alu_ng) | (instr[1] & alu_zr) | (instr[0] & ~alu_ng & ~alu_zr));
  assign outM = alu_o;
  assign writeM = is_c & instr[3] & instr_valid & ~rst;
  assign addressM = a[14:0];
  assign pc = pc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      a    <= '0;
      d    <= '0;
      pc_q <= RESET_PC;
    end else if (instr_valid) begin
      a    <= !is_c ? instr : (instr[5] ? alu_o : a);
      d    <= (is_c && instr[4]) ? alu_o : d;
      pc_q <= jmp ? a[14:0] : pc_q + 15'd1;
    end
  end
endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb_hack_cpu_ctrl: scoreboard bench for hack_cpu_ctrl with a behavioural Hack ALU as environment
module tb_hack_cpu_ctrl;
  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] instr = '0;
  logic        instr_valid = 0;
  logic [15:0] inM = 16'hBEEF;
  logic [15:0] alu_x, alu_y, alu_o, outM;
  logic        zx, nx, zy, ny, f, no, alu_zr, alu_ng, writeM;
  logic [14:0] addressM, pc;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a, d, y, o;
    logic [14:0] pc, addr;
    logic [5:0]  ctl;
    logic        wm;
  } exp_t;
  exp_t sb[$];
  logic [15:0] m_a = '0;
  logic [15:0] m_d = '0;
  logic [14:0] m_pc = '0;

  hack_cpu_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .inM(inM),
    .alu_x(alu_x), .alu_y(alu_y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .alu_o(alu_o), .alu_zr(alu_zr), .alu_ng(alu_ng), .outM(outM), .writeM(writeM),
    .addressM(addressM), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0 : y;
    yy = c[2] ? ~yy : yy;
    o = c[1] ? xx + yy : xx & yy;
    return c[0] ? ~o : o;
  endfunction

  assign alu_o = alu(alu_x, alu_y, {zx, nx, zy, ny, f, no});
  assign alu_zr = (alu_o == 16'h0);
  assign alu_ng = alu_o[15];

  task automatic apply(input logic [15:0] ins, input logic v, input logic r);
    exp_t e;
    logic [15:0] o;
    logic j;
    rst = r;
    instr = ins;
    instr_valid = v;
    e.y = ins[12] ? inM : m_a;
    e.ctl = ins[15] ? ins[11:6] : 6'b0;
    o = alu(m_d, e.y, e.ctl);
    e.o = o;
    e.wm = !r && v && ins[15] && ins[3];
    e.addr = m_a[14:0];
    j = ins[15] && ((ins[2] && o[15]) || (ins[1] && o == 16'h0) || (ins[0] && !o[15] && o != 16'h0));
    if (r) begin
      m_a = '0;
      m_d = '0;
      m_pc = 15'h0000;
    end else if (v) begin
      m_pc = j ? m_a[14:0] : m_pc + 15'd1;
      if (!ins[15]) m_a = ins;
      else begin
        if (ins[5]) m_a = o;
        if (ins[4]) m_d = o;
      end
    end
    e.a = m_a;
    e.d = m_d;
    e.pc = m_pc;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [15:0] seq [2] = '{16'hE308, 16'hE308};
    for (int i = 0; i < 2; i++) begin
      apply(seq[i], 1'b1, 1'b1);
      #2;
      e = sb.pop_front();
      checks += 3;
      if (writeM !== e.wm) begin errors++; $display("FAIL reset[%0d] writeM got %b exp %b", i, writeM, e.wm); end
      if (outM !== e.o) begin errors++; $display("FAIL reset[%0d] outM got %h exp %h", i, outM, e.o); end
      if ({zx, nx, zy, ny, f, no} !== e.ctl) begin errors++; $display("FAIL reset[%0d] ctl got %b exp %b", i, {zx, nx, zy, ny, f, no}, e.ctl); end
      @(posedge clk); #1;
      checks += 3;
      if (addressM !== e.a[14:0]) begin errors++; $display("FAIL reset[%0d] A got %h exp %h", i, addressM, e.a[14:0]); end
      if (alu_x !== e.d) begin errors++; $display("FAIL reset[%0d] D got %h exp %h", i, alu_x, e.d); end
      if (pc !== e.pc) begin errors++; $display("FAIL reset[%0d] pc got %h exp %h", i, pc, e.pc); end
    end
  endtask

  task automatic test_load_copy_write();
    exp_t e;
    logic [15:0] seq [4] = '{16'h0005, 16'hEC10, 16'h0064, 16'hE308};
    for (int i = 0; i < 4; i++) begin
      apply(seq[i], 1'b1, 1'b0);
      #2;
      e = sb.pop_front();
      checks += 5;
      if (writeM !== e.wm) begin errors++; $display("FAIL ldw[%0d] writeM got %b exp %b", i, writeM, e.wm); end
      if (outM !== e.o) begin errors++; $display("FAIL ldw[%0d] outM got %h exp %h", i, outM, e.o); end
      if ({zx, nx, zy, ny, f, no} !== e.ctl) begin errors++; $display("FAIL ldw[%0d] ctl got %b exp %b", i, {zx, nx, zy, ny, f, no}, e.ctl); end
      if (alu_y !== e.y) begin errors++; $display("FAIL ldw[%0d] alu_y got %h exp %h", i, alu_y, e.y); end
      if (addressM !== e.addr) begin errors++; $display("FAIL ldw[%0d] addressM got %h exp %h", i, addressM, e.addr); end
      @(posedge clk); #1;
      checks += 3;
      if (addressM !== e.a[14:0]) begin errors++; $display("FAIL ldw[%0d] A got %h exp %h", i, addressM, e.a[14:0]); end
      if (alu_x !== e.d) begin errors++; $display("FAIL ldw[%0d] D got %h exp %h", i, alu_x, e.d); end
      if (pc !== e.pc) begin errors++; $display("FAIL ldw[%0d] pc got %h exp %h", i, pc, e.pc); end
    end
  endtask

  task automatic test_jumps();
    exp_t e;
    logic [15:0] seq [10] = '{16'h0010, 16'hEA87, 16'hEA90, 16'hE301, 16'hEE90,
                              16'h0020, 16'hE304, 16'h0030, 16'hEAA7, 16'hE302};
    for (int i = 0; i < 10; i++) begin
      apply(seq[i], 1'b1, 1'b0);
      #2;
      e = sb.pop_front();
      checks += 2;
      if (writeM !== e.wm) begin errors++; $display("FAIL jump[%0d] writeM got %b exp %b", i, writeM, e.wm); end
      if (outM !== e.o) begin errors++; $display("FAIL jump[%0d] outM got %h exp %h", i, outM, e.o); end
      @(posedge clk); #1;
      checks += 3;
      if (addressM !== e.a[14:0]) begin errors++; $display("FAIL jump[%0d] A got %h exp %h", i, addressM, e.a[14:0]); end
      if (alu_x !== e.d) begin errors++; $display("FAIL jump[%0d] D got %h exp %h", i, alu_x, e.d); end
      if (pc !== e.pc) begin errors++; $display("FAIL jump[%0d] pc got %h exp %h", i, pc, e.pc); end
    end
  endtask

  task automatic test_stall_wrap();
    exp_t e;
    logic [15:0] seq [7] = '{16'hE318, 16'hE318, 16'hE318, 16'h7FFF, 16'hEA87, 16'h1234, 16'h0042};
    logic        val [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      apply(seq[i], val[i], 1'b0);
      #2;
      e = sb.pop_front();
      checks += 2;
      if (writeM !== e.wm) begin errors++; $display("FAIL stallwrap[%0d] writeM got %b exp %b", i, writeM, e.wm); end
      if ({zx, nx, zy, ny, f, no} !== e.ctl) begin errors++; $display("FAIL stallwrap[%0d] ctl got %b exp %b", i, {zx, nx, zy, ny, f, no}, e.ctl); end
      @(posedge clk); #1;
      checks += 3;
      if (addressM !== e.a[14:0]) begin errors++; $display("FAIL stallwrap[%0d] A got %h exp %h", i, addressM, e.a[14:0]); end
      if (alu_x !== e.d) begin errors++; $display("FAIL stallwrap[%0d] D got %h exp %h", i, alu_x, e.d); end
      if (pc !== e.pc) begin errors++; $display("FAIL stallwrap[%0d] pc got %h exp %h", i, pc, e.pc); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 200; i++) begin
      inM = 16'($urandom);
      apply(16'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      #2;
      e = sb.pop_front();
      checks += 5;
      if (writeM !== e.wm) begin errors++; $display("FAIL b2b[%0d] writeM got %b exp %b", i, writeM, e.wm); end
      if (outM !== e.o) begin errors++; $display("FAIL b2b[%0d] outM got %h exp %h", i, outM, e.o); end
      if ({zx, nx, zy, ny, f, no} !== e.ctl) begin errors++; $display("FAIL b2b[%0d] ctl got %b exp %b", i, {zx, nx, zy, ny, f, no}, e.ctl); end
      if (alu_y !== e.y) begin errors++; $display("FAIL b2b[%0d] alu_y got %h exp %h", i, alu_y, e.y); end
      if (addressM !== e.addr) begin errors++; $display("FAIL b2b[%0d] addressM got %h exp %h", i, addressM, e.addr); end
      @(posedge clk); #1;
      checks += 3;
      if (addressM !== e.a[14:0]) begin errors++; $display("FAIL b2b[%0d] A got %h exp %h", i, addressM, e.a[14:0]); end
      if (alu_x !== e.d) begin errors++; $display("FAIL b2b[%0d] D got %h exp %h", i, alu_x, e.d); end
      if (pc !== e.pc) begin errors++; $display("FAIL b2b[%0d] pc got %h exp %h", i, pc, e.pc); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [15:0] seq [3] = '{16'hEE90, 16'hE308, 16'h0007};
    logic        rs  [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      apply(seq[i], 1'b1, rs[i]);
      #2;
      e = sb.pop_front();
      checks += 1;
      if (writeM !== e.wm) begin errors++; $display("FAIL rstmid[%0d] writeM got %b exp %b", i, writeM, e.wm); end
      @(posedge clk); #1;
      checks += 3;
      if (addressM !== e.a[14:0]) begin errors++; $display("FAIL rstmid[%0d] A got %h exp %h", i, addressM, e.a[14:0]); end
      if (alu_x !== e.d) begin errors++; $display("FAIL rstmid[%0d] D got %h exp %h", i, alu_x, e.d); end
      if (pc !== e.pc) begin errors++; $display("FAIL rstmid[%0d] pc got %h exp %h", i, pc, e.pc); end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_load_copy_write();
    test_jumps();
    test_stall_wrap();
    test_back_to_back();
    test_reset_mid();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover got %0d exp 0", sb.size());
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
